swd_target_phy: RTL and testbench

Serial Wire Debug target-side physical layer: the responder counterpart to the team's SWD host PHY. It watches host-driven SWCLK/SWDIO, decodes and parity-checks 8-bit request packets, and drives the turnaround, 3-bit ACK and read data with parity. It also receives write data with parity and presents decoded transactions to a DP/AP register backend through single-cycle strobes. It serves as the debug-port front end in the target emulator and as the loopback responder for host-PHY regression.

---
 rtl/swd_target_phy.sv | 222 ++++++++++++++++++++++
 tb/tb_swd_target_phy.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_target_phy.sv
// SWD target-side PHY: decodes host requests on SWCLK rises, answers with ACK and
// read data, receives write data, and hands transactions to the DP/AP backend.
module swd_target_phy #(
  parameter int LRST_BITS = 50
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        SWDCLKIN,
  input  logic        SWDIN,
  output logic        SWDOUT,
  output logic        SWDOE,
  input  logic        ACK_FAULT,
  input  logic        ACK_WAIT,
  input  logic [31:0] RDATA,
  output logic        REQ,
  output logic        REQ_APNDP,
  output logic        REQ_RNW,
  output logic [1:0]  REQ_ADDR,
  output logic        RD_ACK,
  output logic        WR_STB,
  output logic [31:0] WDATA,
  output logic        PERR,
  output logic        LINE_RESET
);

  localparam int            LW       = $clog2(LRST_BITS + 1);
  localparam logic [LW-1:0] LRST_MAX = LW'(LRST_BITS);

  typedef enum logic [3:0] {
    ST_LOCKOUT, ST_LRST, ST_IDLE, ST_REQ, ST_TRN,
    ST_ACK, ST_RDATA, ST_RTRN, ST_WDATA
  } state_t;

  logic          sync1_q, sync2_q, clk_prev_q, rise_q;
  state_t        state_q;
  logic [5:0]    slot_q;
  logic [5:0]    req_sh_q;
  logic [2:0]    ack_q;
  logic [31:0]   rsh_q, wsh_q, wdata_q;
  logic          rpar_q;
  logic          swdout_q, swdoe_q;
  logic          req_q, rd_ack_q, wr_stb_q, perr_q, line_reset_q;
  logic          req_apndp_q, req_rnw_q;
  logic [1:0]    req_addr_q;
  logic [LW-1:0] lrst_cnt_q, lrst_cnt_d;
  logic          lrst_hit;
  logic [6:0]    req_full;
  logic          req_ok;
  logic [5:0]    slot_nx;

  // SWCLK synchronizer plus registered rise detect (3 CLK pin-to-event)
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      clk_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync1_q    <= SWDCLKIN;
      sync2_q    <= sync1_q;
      clk_prev_q <= sync2_q;
      rise_q     <= sync2_q & ~clk_prev_q;
    end
  end

  always_comb begin
    lrst_cnt_d = '0;
    lrst_hit   = 1'b0;
    if (SWDIN && !swdoe_q) begin
      lrst_cnt_d = (lrst_cnt_q == LRST_MAX) ? lrst_cnt_q : lrst_cnt_q + 1'b1;
      lrst_hit   = (lrst_cnt_q == LRST_MAX - 1'b1);
    end
  end

  // Request fields by index: APnDP, RnW, A2, A3, Parity, Stop, Park
  assign req_full = {SWDIN, req_sh_q};
  assign req_ok   = req_full[6] && !req_full[5] && ((^req_full[3:0]) == req_full[4]);
  assign slot_nx  = slot_q + 6'd1;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= ST_LOCKOUT;
      slot_q       <= '0;
      req_sh_q     <= '0;
      ack_q        <= '0;
      rsh_q        <= '0;
      wsh_q        <= '0;
      wdata_q      <= '0;
      rpar_q       <= 1'b0;
      swdout_q     <= 1'b0;
      swdoe_q      <= 1'b0;
      req_q        <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      perr_q       <= 1'b0;
      line_reset_q <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_rnw_q    <= 1'b0;
      req_addr_q   <= '0;
      lrst_cnt_q   <= '0;
    end else begin
      req_q        <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      perr_q       <= 1'b0;
      line_reset_q <= 1'b0;
      if (rise_q) begin
        lrst_cnt_q <= lrst_cnt_d;
        if (lrst_hit) begin
          // Line reset wins over whatever slot this rise belonged to
          line_reset_q <= 1'b1;
          state_q      <= ST_LRST;
          swdoe_q      <= 1'b0;
          swdout_q     <= 1'b0;
        end else begin
          case (state_q)
            ST_LOCKOUT: ;
            ST_LRST: if (!SWDIN) state_q <= ST_IDLE;
            ST_IDLE: if (SWDIN) begin
              state_q <= ST_REQ;
              slot_q  <= '0;
            end
            ST_REQ: begin
              slot_q   <= slot_nx;
              req_sh_q <= req_full[6:1];
              if (slot_nx == 6'd7) begin
                if (req_ok) begin
                  req_q       <= 1'b1;
                  req_apndp_q <= req_full[0];
                  req_rnw_q   <= req_full[1];
                  req_addr_q  <= {req_full[3], req_full[2]};
                  state_q     <= ST_TRN;
                end else begin
                  state_q <= ST_LOCKOUT;
                end
              end
            end
            ST_TRN: begin
              slot_q  <= slot_nx;
              state_q <= ST_ACK;
              if (ACK_FAULT)     ack_q <= 3'b100;
              else if (ACK_WAIT) ack_q <= 3'b010;
              else begin
                ack_q <= 3'b001;
                if (req_rnw_q) begin
                  rsh_q    <= RDATA;
                  rpar_q   <= ^RDATA;
                  rd_ack_q <= 1'b1;
                end
              end
            end
            ST_ACK: begin
              slot_q <= slot_nx;
              case (slot_nx)
                6'd9: begin
                  swdoe_q  <= 1'b1;
                  swdout_q <= ack_q[0];
                end
                6'd10: swdout_q <= ack_q[1];
                6'd11: swdout_q <= ack_q[2];
                default: begin
                  if (ack_q == 3'b001 && req_rnw_q) begin
                    swdout_q <= rsh_q[0];
                    rsh_q    <= {1'b0, rsh_q[31:1]};
                    state_q  <= ST_RDATA;
                  end else begin
                    swdoe_q  <= 1'b0;
                    swdout_q <= 1'b0;
                    state_q  <= (ack_q == 3'b001) ? ST_WDATA : ST_IDLE;
                  end
                end
              endcase
            end
            ST_RDATA: begin
              slot_q <= slot_nx;
              if (slot_nx == 6'd44) begin
                swdout_q <= rpar_q;
                state_q  <= ST_RTRN;
              end else begin
                swdout_q <= rsh_q[0];
                rsh_q    <= {1'b0, rsh_q[31:1]};
              end
            end
            ST_RTRN: begin
              swdoe_q  <= 1'b0;
              swdout_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
            ST_WDATA: begin
              slot_q <= slot_nx;
              if (slot_nx == 6'd45) begin
                if ((^wsh_q) == SWDIN) begin
                  wdata_q  <= wsh_q;
                  wr_stb_q <= 1'b1;
                end else begin
                  perr_q <= 1'b1;
                end
                state_q <= ST_IDLE;
              end else begin
                wsh_q <= {SWDIN, wsh_q[31:1]};
              end
            end
            default: state_q <= ST_LOCKOUT;
          endcase
        end
      end
    end
  end

  assign SWDOUT     = swdout_q;
  assign SWDOE      = swdoe_q;
  assign REQ        = req_q;
  assign REQ_APNDP  = req_apndp_q;
  assign REQ_RNW    = req_rnw_q;
  assign REQ_ADDR   = req_addr_q;
  assign RD_ACK     = rd_ack_q;
  assign WR_STB     = wr_stb_q;
  assign WDATA      = wdata_q;
  assign PERR       = perr_q;
  assign LINE_RESET = line_reset_q;

endmodule

// File: tb/tb_swd_target_phy.sv
// Bench for swd_target_phy: acts as SWD host at 16 CLK per SWCLK period and checks
// every slot against a transaction-level model of the protocol.
module tb_swd_target_phy;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        SWDCLKIN = 1'b0;
  logic        SWDIN = 1'b0;
  logic        ACK_FAULT = 1'b0;
  logic        ACK_WAIT = 1'b0;
  logic [31:0] RDATA = '0;
  logic        SWDOUT, SWDOE, REQ, REQ_APNDP, REQ_RNW, RD_ACK, WR_STB, PERR, LINE_RESET;
  logic [1:0]  REQ_ADDR;
  logic [31:0] WDATA;

  int n_tests = 0;
  int n_fail  = 0;
  int n_req = 0, n_rdack = 0, n_wr = 0, n_perr = 0, n_lr = 0;

  // Transaction-level model of the target as the host sees it
  logic        locked;
  logic        m_apndp, m_rnw;
  logic [1:0]  m_addr;
  logic [31:0] m_wdata;

  always #5 CLK = ~CLK;

  swd_target_phy #(.LRST_BITS(50)) dut (
    .CLK(CLK), .RESETn(RESETn), .SWDCLKIN(SWDCLKIN), .SWDIN(SWDIN),
    .SWDOUT(SWDOUT), .SWDOE(SWDOE), .ACK_FAULT(ACK_FAULT), .ACK_WAIT(ACK_WAIT),
    .RDATA(RDATA), .REQ(REQ), .REQ_APNDP(REQ_APNDP), .REQ_RNW(REQ_RNW),
    .REQ_ADDR(REQ_ADDR), .RD_ACK(RD_ACK), .WR_STB(WR_STB), .WDATA(WDATA),
    .PERR(PERR), .LINE_RESET(LINE_RESET)
  );

  // High-cycle counters: a 1-CLK pulse per event means one count per event
  always @(negedge CLK) begin
    if (REQ)        n_req++;
    if (RD_ACK)     n_rdack++;
    if (WR_STB)     n_wr++;
    if (PERR)       n_perr++;
    if (LINE_RESET) n_lr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slot(input logic din, output logic dout, output logic oe);
    @(negedge CLK);
    SWDCLKIN = 1'b0;
    SWDIN    = din;
    repeat (7) @(negedge CLK);
    SWDCLKIN = 1'b1;
    repeat (8) @(negedge CLK);
    dout = SWDOUT;
    oe   = SWDOE;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn   = 1'b0;
    SWDCLKIN = 1'b0;
    SWDIN    = 1'b0;
    repeat (2) @(negedge CLK);
    RESETn  = 1'b1;
    locked  = 1'b1;
    m_apndp = 1'b0;
    m_rnw   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  function automatic logic [7:0] req_byte(input logic apndp, input logic rnw,
                                          input logic [1:0] addr, input logic bad);
    logic par;
    par = apndp ^ rnw ^ addr[0] ^ addr[1] ^ bad;
    return {1'b1, 1'b0, par, addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

  task automatic check_fields(input string tag);
    chk(tag, 32'({REQ_APNDP, REQ_RNW, REQ_ADDR}), 32'({m_apndp, m_rnw, m_addr}));
  endtask

  task automatic line_reset();
    logic d, o;
    int   lr0, rq0;
    slot(1'b0, d, o);
    lr0 = n_lr;
    rq0 = n_req;
    for (int i = 0; i < 49; i++) slot(1'b1, d, o);
    chk("lr_early", n_lr - lr0, 0);
    slot(1'b1, d, o);
    chk("lr_pulse", n_lr - lr0, 1);
    slot(1'b0, d, o);
    chk("lr_noreq", n_req - rq0, 0);
    chk("lr_oe", 32'(o), 0);
    locked = 1'b0;
  endtask

  task automatic xfer(input logic apndp, input logic rnw, input logic [1:0] addr,
                      input logic bad_rpar, input logic fault, input logic wt,
                      input logic [31:0] rd, input logic [31:0] wd, input logic bad_wpar);
    logic [7:0]  rq;
    logic [2:0]  ack, ack_exp;
    logic [31:0] got;
    logic        d, o, oe_any, oe_all, accept, ok;
    int          rq0, ra0, wr0, pe0;
    ACK_FAULT = fault;
    ACK_WAIT  = wt;
    RDATA     = rd;
    rq     = req_byte(apndp, rnw, addr, bad_rpar);
    accept = !locked && !bad_rpar;
    ok     = !fault && !wt;
    // Expected ACK in wire order, first element = slot 9
    ack_exp = fault ? 3'b100 : (wt ? 3'b010 : 3'b001);
    rq0 = n_req; ra0 = n_rdack; wr0 = n_wr; pe0 = n_perr;
    oe_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      slot(rq[i], d, o);
      oe_any |= o;
    end
    chk("req_pulse", n_req - rq0, 32'(accept));
    if (accept) begin
      m_apndp = apndp;
      m_rnw   = rnw;
      m_addr  = addr;
    end
    check_fields("req_fields");
    if (!accept) begin
      for (int i = 0; i < 5; i++) begin
        slot(1'b0, d, o);
        oe_any |= o;
      end
      chk("nodrive_oe", 32'(oe_any), 0);
      chk("nodrive_rdack", n_rdack - ra0, 0);
      if (bad_rpar) locked = 1'b1;
      return;
    end
    slot(1'b0, d, o);
    chk("trn_oe", 32'(o), 0);
    chk("rd_ack", n_rdack - ra0, 32'(ok && rnw));
    oe_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, d, o);
      ack[i] = d;
      oe_all &= o;
    end
    chk("ack_oe", 32'(oe_all), 1);
    chk("ack_bits", 32'(ack), 32'(ack_exp));
    if (!ok || !rnw) begin
      slot(1'b0, d, o);
      chk("trn2_oe", 32'(o), 0);
    end
    if (!ok) return;
    if (rnw) begin
      for (int i = 0; i < 32; i++) begin
        slot(1'b0, d, o);
        got[i] = d;
        oe_all &= o;
      end
      chk("rd_data", got, rd);
      slot(1'b0, d, o);
      oe_all &= o;
      chk("rd_par", 32'(d), 32'(^rd));
      chk("rd_oe", 32'(oe_all), 1);
      slot(1'b0, d, o);
      chk("rtrn", 32'({o, d}), 0);
      chk("rd_nostb", (n_wr - wr0) + (n_perr - pe0), 0);
    end else begin
      for (int i = 0; i < 32; i++) slot(wd[i], d, o);
      slot((^wd) ^ bad_wpar, d, o);
      if (!bad_wpar) m_wdata = wd;
      chk("wr_stb", n_wr - wr0, 32'(!bad_wpar));
      chk("perr", n_perr - pe0, 32'(bad_wpar));
      chk("wdata", WDATA, m_wdata);
    end
  endtask

  initial begin
    logic [7:0] rq;
    logic       d, o, oe_any;
    int         wr0, pe0;
    do_reset();
    chk("rst_outs", 32'({SWDOUT, SWDOE, REQ, RD_ACK, WR_STB, PERR, LINE_RESET,
                         REQ_APNDP, REQ_RNW, REQ_ADDR}), 0);
    chk("rst_wdata", WDATA, 0);

    // Lockout after power-up, then line reset unlocks
    xfer(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h2BA01477, '0, 1'b0);
    line_reset();

    xfer(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h2BA01477, '0, 1'b0);
    xfer(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, '0, 32'h12345678, 1'b0);
    xfer(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, '0, 32'hCAFEF00D, 1'b1);

    // Bad request parity locks out until a line reset
    xfer(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h1, '0, 1'b0);
    xfer(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h1, '0, 1'b0);
    line_reset();

    xfer(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, '0, 1'b0);
    xfer(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, '0, 1'b0);
    xfer(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, '0, 32'h55AA55AA, 1'b0);

    // Reset in the middle of write data
    ACK_FAULT = 1'b0;
    ACK_WAIT  = 1'b0;
    rq = req_byte(1'b1, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) slot(rq[i], d, o);
    for (int i = 0; i < 5; i++) slot(1'b0, d, o);
    for (int i = 0; i < 20; i++) slot(1'b1, d, o);
    wr0 = n_wr;
    pe0 = n_perr;
    @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    chk("midrst_outs", 32'({SWDOUT, SWDOE, REQ_APNDP, REQ_RNW, REQ_ADDR}), 0);
    chk("midrst_wdata", WDATA, 0);
    do_reset();
    oe_any = 1'b0;
    for (int i = 0; i < 13; i++) begin
      slot(1'b1, d, o);
      oe_any |= o;
    end
    chk("midrst_nostb", (n_wr - wr0) + (n_perr - pe0), 0);
    chk("midrst_oe", 32'(oe_any), 0);
    xfer(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, '0, 32'h0BADF00D, 1'b0);
    line_reset();

    for (int t = 0; t < 24; t++) begin
      xfer(1'($urandom), 1'($urandom), 2'($urandom), ($urandom % 8) == 0,
           ($urandom % 6) == 0, ($urandom % 5) == 0, $urandom, $urandom,
           ($urandom % 6) == 0);
      if (locked) begin
        if ($urandom % 2 == 0)
          xfer(1'($urandom), 1'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0,
               $urandom, $urandom, 1'b0);
        line_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
